mem1rw_arbiter: RTL

Two-requester arbiter that shares one single-port 32x64 synchronous memory (one access per cycle, read or write) between two clients. It accepts valid/ready requests, grants at most one per cycle, and drives the memory's shared address, write-data and write-enable lines. It returns a one-cycle response pulse to the winning requester on the cycle after the grant, carrying read data for reads. It sits directly in front of the memory instance; clients never touch the memory ports.

---
 rtl/mem1rw_arbiter.sv | 68 ++++++
 1 files changed

// File: rtl/mem1rw_arbiter.sv
// mem1rw_arbiter: two-port valid/ready arbiter in front of one single-port synchronous memory.
// Define MEM1RW_ARB_RR_EN for round-robin; undefined gives fixed priority to port 0.
module mem1rw_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid_0,
    output logic              req_ready_0,
    input  logic              req_we_0,
    input  logic [ADDR_W-1:0] req_addr_0,
    input  logic [DATA_W-1:0] req_wdata_0,
    output logic              resp_valid_0,
    input  logic              req_valid_1,
    output logic              req_ready_1,
    input  logic              req_we_1,
    input  logic [ADDR_W-1:0] req_addr_1,
    input  logic [DATA_W-1:0] req_wdata_1,
    output logic              resp_valid_1,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);
    logic grant_0, grant_1;
    logic pend_valid, pend_port, pend_read;

`ifdef MEM1RW_ARB_RR_EN
    logic last_grant;
    // last_grant = 1 means port 1 won last, so port 0 wins the next contention
    assign grant_0 = req_valid_0 & (~req_valid_1 | last_grant);
    always_ff @(posedge clock) begin
        if (reset)
            last_grant <= 1'b1;
        else if (grant_0 | grant_1)
            last_grant <= grant_1;
    end
`else
    assign grant_0 = req_valid_0;
`endif

    assign grant_1     = req_valid_1 & ~grant_0;
    assign req_ready_0 = grant_0;
    assign req_ready_1 = grant_1;

    // No grant drives an idle read of address 0
    assign mem_we    = grant_1 ? req_we_1    : grant_0 ? req_we_0    : 1'b0;
    assign mem_addr  = grant_1 ? req_addr_1  : grant_0 ? req_addr_0  : '0;
    assign mem_wdata = grant_1 ? req_wdata_1 : grant_0 ? req_wdata_0 : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_port  <= 1'b0;
            pend_read  <= 1'b0;
        end else begin
            pend_valid <= grant_0 | grant_1;
            pend_port  <= grant_1;
            pend_read  <= grant_1 ? ~req_we_1 : grant_0 ? ~req_we_0 : 1'b0;
        end
    end

    assign resp_valid_0 = pend_valid & ~pend_port;
    assign resp_valid_1 = pend_valid & pend_port;
    assign resp_rdata   = (pend_valid & pend_read) ? mem_rdata : '0;
endmodule
